// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave timer blocks.
package microondas_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;
  localparam bcd_t BCD_NINE         = 4'd9;
  localparam int   SECS_ADD         = 30;

  // SECS_ADD is a whole number of tens, so adding it only touches sec_tens
  // (plus the carry into minutes).
  localparam bcd_t ADD_SEC_TENS = bcd_t'(SECS_ADD / 10);

endpackage

// File: rtl/temporizador_bcd_tick_gen.sv
// tick_gen: one-second prescaler. Counts while en=1, holds while en=0,
// and emits a one-cycle tick on the last count of each second.
module tick_gen #(
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_SEC - 1);

  logic [W-1:0] r_cnt;

  // Tick is combinational so the digits move on the same edge the prescaler wraps.
  assign o_tick = i_en && (r_cnt == LAST);

  // Prescaler: clear wins over enable; wrap to 0 on the tick.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temporizador_bcd.sv
// temporizador_bcd: BCD mm:ss cook timer, keypad-loaded, counts down while
// the magnetron is on. Optional "+30 s" key enabled by TIMER_ADD30_EN.
//
// Keypad handshake: key_valid is a one-cycle strobe with no back-pressure;
// key_digit is sampled only in that cycle, and a key that is not accepted
// (magnetron on, or digit would form an illegal time) is simply dropped.
module temporizador_bcd
  import microondas_pkg::*;
#(
  parameter int CLKS_PER_SEC = 50_000_000,
  parameter int MAX_MIN_TENS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       add30,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done
);

  localparam bcd_t MAX_MT = bcd_t'(MAX_MIN_TENS);

  bcd_t r_mt, r_mo, r_st, r_so;
  logic r_done;

  logic w_zero, w_key_ok, w_tick;
  bcd_t w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
  bcd_t w_base_mt, w_base_mo, w_base_st, w_base_so;
  bcd_t w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;

  assign w_zero = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);

  // A key is legal only if the shifted-in layout stays a valid time.
  assign w_key_ok = key_valid && !mag_on && (key_digit <= BCD_NINE)
                    && (r_so <= BCD_MAX_SEC_TENS) && (r_mo <= MAX_MT);

  tick_gen #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (!clearn || w_key_ok || w_zero),
    .i_en   (mag_on && !w_zero),
    .o_tick (w_tick)
  );

  // One-second BCD decrement with borrow; only used when the count is nonzero.
  always_comb begin
    w_dec_mt = r_mt;
    w_dec_mo = r_mo;
    w_dec_st = r_st;
    w_dec_so = r_so;
    if (r_so != 4'd0) begin
      w_dec_so = r_so - 4'd1;
    end else begin
      w_dec_so = BCD_NINE;
      if (r_st != 4'd0) begin
        w_dec_st = r_st - 4'd1;
      end else begin
        w_dec_st = BCD_MAX_SEC_TENS;
        if (r_mo != 4'd0) begin
          w_dec_mo = r_mo - 4'd1;
        end else begin
          w_dec_mo = BCD_NINE;
          w_dec_mt = r_mt - 4'd1;
        end
      end
    end
  end

  // Key shift and countdown are exclusive (entry needs mag_on=0, ticks need mag_on=1).
  always_comb begin
    w_base_mt = r_mt;
    w_base_mo = r_mo;
    w_base_st = r_st;
    w_base_so = r_so;
    if (w_key_ok) begin
      w_base_mt = r_mo;
      w_base_mo = r_st;
      w_base_st = r_so;
      w_base_so = key_digit;
    end else if (w_tick) begin
      w_base_mt = w_dec_mt;
      w_base_mo = w_dec_mo;
      w_base_st = w_dec_st;
      w_base_so = w_dec_so;
    end
  end

`ifdef TIMER_ADD30_EN
  bcd_t w_st_sum;

  // +30 s on top of the keyed/decremented value, saturating at MAX_MT9:59.
  always_comb begin
    w_nxt_mt = w_base_mt;
    w_nxt_mo = w_base_mo;
    w_nxt_st = w_base_st;
    w_nxt_so = w_base_so;
    w_st_sum = w_base_st + ADD_SEC_TENS;
    if (add30 && !w_key_ok) begin
      if (w_st_sum <= BCD_MAX_SEC_TENS) begin
        w_nxt_st = w_st_sum;
      end else if ((w_base_mt >= MAX_MT) && (w_base_mo == BCD_NINE)) begin
        w_nxt_mt = MAX_MT;
        w_nxt_mo = BCD_NINE;
        w_nxt_st = BCD_MAX_SEC_TENS;
        w_nxt_so = BCD_NINE;
      end else begin
        w_nxt_st = w_st_sum - 4'd6;
        if (w_base_mo == BCD_NINE) begin
          w_nxt_mo = 4'd0;
          w_nxt_mt = w_base_mt + 4'd1;
        end else begin
          w_nxt_mo = w_base_mo + 4'd1;
        end
      end
    end
  end
`else
  logic w_unused_add30;
  assign w_unused_add30 = add30;

  // Without the +30 s feature the next count is the keyed/decremented value.
  always_comb begin
    w_nxt_mt = w_base_mt;
    w_nxt_mo = w_base_mo;
    w_nxt_st = w_base_st;
    w_nxt_so = w_base_so;
  end
`endif

  // Count register; timer_done is registered alongside so it tracks the digits.
  always_ff @(posedge clk) begin
    if (rst || !clearn) begin
      r_mt   <= 4'd0;
      r_mo   <= 4'd0;
      r_st   <= 4'd0;
      r_so   <= 4'd0;
      r_done <= 1'b1;
    end else begin
      r_mt   <= w_nxt_mt;
      r_mo   <= w_nxt_mo;
      r_st   <= w_nxt_st;
      r_so   <= w_nxt_so;
      r_done <= (w_nxt_mt == 4'd0) && (w_nxt_mo == 4'd0)
                && (w_nxt_st == 4'd0) && (w_nxt_so == 4'd0);
    end
  end

  assign min_tens   = r_mt;
  assign min_ones   = r_mo;
  assign sec_tens   = r_st;
  assign sec_ones   = r_so;
  assign timer_done = r_done;

endmodule
